// File: rtl/bsg_scatter_gather_iter.sv
// Iterative scatter/gather index generator: walks a bit vector slice_p bits per
// cycle, producing gather (fwd) indices, scatter (bk) ranks and a popcount.
module bsg_scatter_gather_iter #(
  parameter int vec_size_p = 32,
  parameter int slice_p    = 8,
  parameter int lg_vec_lp  = $clog2(vec_size_p),
  parameter int lg_cnt_lp  = $clog2(vec_size_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic [vec_size_p-1:0]           vec_i,
  output logic                            ready_o,
  output logic                            v_o,
  input  logic                            yumi_i,
  output logic [vec_size_p*lg_vec_lp-1:0] fwd_o,
  output logic [vec_size_p*lg_vec_lp-1:0] bk_o,
  output logic [lg_cnt_lp-1:0]            count_o
);

  localparam int n_slices_lp = vec_size_p / slice_p;
  localparam int lg_k_lp     = (n_slices_lp > 1) ? $clog2(n_slices_lp) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                            state_r, state_n;
  logic [vec_size_p-1:0]             vec_r, vec_n;
  logic [lg_k_lp-1:0]                k_r, k_n;
  logic [lg_cnt_lp-1:0]              count_r, count_n;
  logic [vec_size_p*lg_vec_lp-1:0]   fwd_r, fwd_n, bk_r, bk_n;

  // NOTE: every register, including the fwd/bk result arrays, is reset so the
  // outputs read as zero after reset; these are flops, not a RAM.
  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      vec_r   <= '0;
      k_r     <= '0;
      count_r <= '0;
      fwd_r   <= '0;
      bk_r    <= '0;
    end else begin
      state_r <= state_n;
      vec_r   <= vec_n;
      k_r     <= k_n;
      count_r <= count_n;
      fwd_r   <= fwd_n;
      bk_r    <= bk_n;
    end
  end

  // NOTE: every signal gets a default first, so no path leaves it unassigned
  // and no latch is inferred. Blocking updates of count_n chain the ranks of
  // all set bits within one slice.
  always_comb begin
    state_n = state_r;
    vec_n   = vec_r;
    k_n     = k_r;
    count_n = count_r;
    fwd_n   = fwd_r;
    bk_n    = bk_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    unique case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          vec_n   = vec_i;
          k_n     = '0;
          count_n = '0;
          fwd_n   = '0;
          bk_n    = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        for (int b = 0; b < slice_p; b++) begin
          if (vec_r[int'(k_r)*slice_p + b]) begin
            bk_n[(int'(k_r)*slice_p + b)*lg_vec_lp +: lg_vec_lp] = lg_vec_lp'(count_n);
            fwd_n[int'(count_n)*lg_vec_lp +: lg_vec_lp] = lg_vec_lp'(int'(k_r)*slice_p + b);
            count_n = count_n + 1'b1;
          end
        end
        if (k_r == lg_k_lp'(n_slices_lp - 1)) state_n = DONE;
        else                                  k_n     = k_r + 1'b1;
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign fwd_o   = fwd_r;
  assign bk_o    = bk_r;
  assign count_o = count_r;

  // Consumers may only take results that are being offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
